// File: rtl/bicubic_pkg.sv
// Shared types and defaults for the bicubic memory responder.
//   state_t : responder FSM states (fixed 2-bit encoding, matches legacy dumps)
//   addr_t  : 14-bit engine/host address
//   pix_t   : 8-bit pixel
//   len_t   : 12-bit result stream length (TW*TH)
//   sum_t   : 16-bit running checksum
package bicubic_pkg;

  localparam int unsigned DEF_IMG_W     = 100;
  localparam int unsigned DEF_IMG_DEPTH = 10000;
  localparam int unsigned DEF_RES_DEPTH = 4096;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned SUM_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [SUM_W-1:0]  sum_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2,
    DUMP  = 2'd3
  } state_t;

endpackage

// File: rtl/bicubic_mem_responder_if.sv
// Bus bundle between host/engine (master) and the memory responder (slave).
//   load_*        : host image load handshake (load_done pulses at end)
//   ird/iaddr/input_data          : engine read port, 1-cycle latency
//   we/waddr/output_data          : engine result write port
//   DONE/dump_len                 : engine completion and stream length
//   out_valid/out_data/out_last/out_ready : result stream
//   busy/err_oob/checksum         : status
interface bicubic_mem_responder_if;
  import bicubic_pkg::*;

  logic  load_start;
  logic  load_valid;
  pix_t  load_data;
  logic  load_ready;
  logic  load_done;
  logic  ird;
  addr_t iaddr;
  pix_t  input_data;
  logic  we;
  addr_t waddr;
  pix_t  output_data;
  logic  DONE;
  len_t  dump_len;
  logic  out_valid;
  pix_t  out_data;
  logic  out_last;
  logic  out_ready;
  logic  busy;
  logic  err_oob;
  sum_t  checksum;

  modport master (
    output load_start, load_valid, load_data, ird, iaddr, we, waddr,
           output_data, DONE, dump_len, out_ready,
    input  load_ready, load_done, input_data, out_valid, out_data,
           out_last, busy, err_oob, checksum
  );

  modport slave (
    input  load_start, load_valid, load_data, ird, iaddr, we, waddr,
           output_data, DONE, dump_len, out_ready,
    output load_ready, load_done, input_data, out_valid, out_data,
           out_last, busy, err_oob, checksum
  );

endinterface

// File: rtl/bicubic_sp_ram.sv
// Single-port RAM with registered read.
//   CLK   : clock
//   we    : write enable (wdata -> mem[addr])
//   re    : read enable; rdata only updates when re=1, otherwise holds
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data (old contents on simultaneous read/write)
// Contents and rdata are not reset.
module bicubic_sp_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bicubic_mem_responder.sv
// Memory-side responder for the bicubic resize engine.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : slave side of bicubic_mem_responder_if
// Holds the source image (loaded by the host), serves engine reads with
// one-cycle latency, captures engine writes into a result buffer with a
// running checksum, and streams the result buffer out after DONE.
module bicubic_mem_responder import bicubic_pkg::*; #(
  parameter int unsigned IMG_W     = DEF_IMG_W,
  parameter int unsigned IMG_DEPTH = DEF_IMG_DEPTH,
  parameter int unsigned RES_DEPTH = DEF_RES_DEPTH
) (
  input logic                     CLK,
  input logic                     RST,
  bicubic_mem_responder_if.slave  bus
);

  localparam int unsigned IAW = $clog2(IMG_DEPTH);
  localparam int unsigned RAW = $clog2(RES_DEPTH);
  // One extra bit so a depth of 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] IMG_LIM   = (ADDR_W+1)'(IMG_DEPTH);
  localparam logic [ADDR_W:0] RES_LIM   = (ADDR_W+1)'(RES_DEPTH);
  localparam addr_t           LOAD_LAST = ADDR_W'(IMG_DEPTH - 1);

  if (IMG_W == 0 || IMG_W > IMG_DEPTH ||
      IMG_DEPTH > 2**ADDR_W || RES_DEPTH > 2**ADDR_W) begin : g_param_check
    $error("bicubic_mem_responder: inconsistent IMG_W/IMG_DEPTH/RES_DEPTH");
  end

  state_t state;
  addr_t  cnt;
  addr_t  ptr;
  len_t   len;
  logic   loaded;
  logic   zero_q;
  logic   out_valid_q;
  logic   load_done_q;
  logic   err_q;
  sum_t   csum;

  logic           serve;
  logic           rd_ok;
  logic           wr_ok;
  logic           load_acc;
  logic           fire;
  logic           last;
  addr_t          res_rd_ptr;
  logic [IAW-1:0] img_addr;
  logic [RAW-1:0] res_addr;
  pix_t           img_rdata;
  pix_t           res_rdata;

  always_comb begin
    serve      = (state == SERVE);
    rd_ok      = serve && bus.ird && ({1'b0, bus.iaddr} < IMG_LIM);
    wr_ok      = serve && bus.we  && ({1'b0, bus.waddr} < RES_LIM);
    load_acc   = (state == LOAD) && bus.load_valid && !bus.load_start;
    fire       = (state == DUMP) && out_valid_q && bus.out_ready;
    last       = (ptr == ({2'b00, len} - 14'd1));
    // Prefetch the next byte on a transfer so out_data never bubbles.
    res_rd_ptr = fire ? ptr + 14'd1 : ptr;
    img_addr   = (state == LOAD) ? cnt[IAW-1:0] : bus.iaddr[IAW-1:0];
    res_addr   = (state == DUMP) ? res_rd_ptr[RAW-1:0] : bus.waddr[RAW-1:0];
  end

  bicubic_sp_ram #(
    .DEPTH (IMG_DEPTH),
    .WIDTH (PIX_W),
    .AW    (IAW)
  ) u_img (
    .CLK   (CLK),
    .we    (load_acc),
    .re    (rd_ok),
    .addr  (img_addr),
    .wdata (bus.load_data),
    .rdata (img_rdata)
  );

  bicubic_sp_ram #(
    .DEPTH (RES_DEPTH),
    .WIDTH (PIX_W),
    .AW    (RAW)
  ) u_res (
    .CLK   (CLK),
    .we    (wr_ok),
    .re    (state == DUMP),
    .addr  (res_addr),
    .wdata (bus.output_data),
    .rdata (res_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      len         <= '0;
      loaded      <= 1'b0;
      // Forces input_data to 0 until a valid read lands in the RAM register.
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      csum        <= '0;
    end else begin
      load_done_q <= 1'b0;

      // Read data register holds when ird=0; invalid reads return 0.
      if (bus.ird) zero_q <= !rd_ok;

      if (serve && bus.ird && !({1'b0, bus.iaddr} < IMG_LIM)) err_q <= 1'b1;
      if (serve && bus.we  && !({1'b0, bus.waddr} < RES_LIM)) err_q <= 1'b1;

      if (wr_ok) csum <= csum + {8'h00, bus.output_data};

      case (state)
        IDLE: begin
          if (bus.load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end else if (loaded) begin
            state <= SERVE;
          end
        end

        LOAD: begin
          if (bus.load_start) begin
            cnt <= '0;
          end else if (bus.load_valid) begin
            if (cnt == LOAD_LAST) begin
              load_done_q <= 1'b1;
              loaded      <= 1'b1;
              state       <= SERVE;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 14'd1;
            end
          end
        end

        SERVE: begin
          if (bus.load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end else if (bus.DONE) begin
            len <= bus.dump_len;
            ptr <= '0;
            if (bus.dump_len != '0) state <= DUMP;
          end
        end

        DUMP: begin
          // Entry cycle issues the read of byte 0; valid follows a cycle later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            if (last) begin
              state       <= SERVE;
              out_valid_q <= 1'b0;
              csum        <= '0;
            end else begin
              ptr <= ptr + 14'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = (state == LOAD);
  assign bus.load_done  = load_done_q;
  assign bus.input_data = zero_q ? '0 : img_rdata;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_valid_q ? res_rdata : '0;
  assign bus.out_last   = out_valid_q && last;
  assign bus.busy       = (state == LOAD) || (state == DUMP);
  assign bus.err_oob    = err_q;
  assign bus.checksum   = csum;

endmodule
